// File: rtl/my_cpu_pkg.sv
// Shared decode constants and the decoded C-instruction record for the Hack-style core.
package cpu_pkg;

    localparam int WIDTH  = 16;
    localparam int AWIDTH = 15;

    localparam int BIT_CI = 15;
    localparam int BIT_A  = 12;
    localparam int ALU_HI = 11;
    localparam int ALU_LO = 6;
    localparam int DST_HI = 5;
    localparam int DST_LO = 3;
    localparam int JMP_HI = 2;
    localparam int JMP_LO = 0;

    // alu = {zx, nx, zy, ny, f, no}; dst = {dA, dD, dM}; jmp = {jlt, jeq, jgt}
    typedef struct packed {
        logic       is_c;
        logic       a;
        logic [5:0] alu;
        logic [2:0] dst;
        logic [2:0] jmp;
    } cinstr_t;

endpackage

// File: rtl/my_alu.sv
// Hack ALU: optional zero/negate of each operand, add or AND, optional output negate.
module my_alu #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic             i_zx,
    input  logic             i_nx,
    input  logic             i_zy,
    input  logic             i_ny,
    input  logic             i_f,
    input  logic             i_no,
    output logic [WIDTH-1:0] o_out,
    output logic             o_zr
);

    logic [WIDTH-1:0] w_x0, w_x1, w_y0, w_y1, w_f;

    always_comb begin
        w_x0  = i_zx ? '0 : i_x;
        w_x1  = i_nx ? ~w_x0 : w_x0;
        w_y0  = i_zy ? '0 : i_y;
        w_y1  = i_ny ? ~w_y0 : w_y0;
        w_f   = i_f ? (w_x1 + w_y1) : (w_x1 & w_y1);
        o_out = i_no ? ~w_f : w_f;
        o_zr  = (o_out == '0);
    end

endmodule

// File: rtl/my_pc.sv
// Program counter: async active-low reset, priority load > increment > hold.
module my_pc #(
    parameter int                AWIDTH   = 15,
    parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_inc,
    input  logic [AWIDTH-1:0] i_d,
    output logic [AWIDTH-1:0] o_q
);

    logic [AWIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_q <= RESET_PC;
        else if (i_load)
            r_q <= i_d;
        else if (i_inc)
            r_q <= r_q + AWIDTH'(1);
    end

    assign o_q = r_q;

endmodule

// File: rtl/my_cpu.sv
// Hack-style CPU core: decodes A/C instructions, drives my_alu, owns A, D and PC.
module my_cpu #(
    parameter int                WIDTH    = 16,
    parameter int                AWIDTH   = 15,
    parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  instruction,
    input  logic              instr_valid,
    input  logic [WIDTH-1:0]  in_m,
    output logic [WIDTH-1:0]  out_m,
    output logic              write_m,
    output logic [AWIDTH-1:0] address_m,
    output logic [AWIDTH-1:0] pc
);

    import cpu_pkg::*;

    logic [WIDTH-1:0] r_a, r_d;
    cinstr_t          w_dec;
    logic [WIDTH-1:0] w_y, w_alu_out;
    logic             w_zr, w_neg, w_pos, w_jump;
    logic             w_unused_bits;

    always_comb begin
        w_dec.is_c = instruction[BIT_CI];
        w_dec.a    = instruction[BIT_A];
        w_dec.alu  = instruction[ALU_HI:ALU_LO];
        w_dec.dst  = instruction[DST_HI:DST_LO];
        w_dec.jmp  = instruction[JMP_HI:JMP_LO];
    end

    assign w_unused_bits = ^instruction[14:13];
    assign w_y           = w_dec.a ? in_m : r_a;

    my_alu #(.WIDTH(WIDTH)) u_alu (
        .i_x   (r_d),
        .i_y   (w_y),
        .i_zx  (w_dec.alu[5]),
        .i_nx  (w_dec.alu[4]),
        .i_zy  (w_dec.alu[3]),
        .i_ny  (w_dec.alu[2]),
        .i_f   (w_dec.alu[1]),
        .i_no  (w_dec.alu[0]),
        .o_out (w_alu_out),
        .o_zr  (w_zr)
    );

    assign w_neg  = w_alu_out[WIDTH-1];
    assign w_pos  = !w_zr && !w_neg;
    assign w_jump = w_dec.is_c && ((w_dec.jmp[2] && w_neg) ||
                                   (w_dec.jmp[1] && w_zr)  ||
                                   (w_dec.jmp[0] && w_pos));

    // Jump target is the pre-update A, even when the same instruction writes A.
    my_pc #(.AWIDTH(AWIDTH), .RESET_PC(RESET_PC)) u_pc (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (instr_valid && w_jump),
        .i_inc  (instr_valid && !w_jump),
        .i_d    (r_a[AWIDTH-1:0]),
        .o_q    (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
            r_d <= '0;
        end else if (instr_valid) begin
            if (!w_dec.is_c)
                r_a <= instruction;
            else if (w_dec.dst[2])
                r_a <= w_alu_out;
            if (w_dec.is_c && w_dec.dst[1])
                r_d <= w_alu_out;
        end
    end

    assign out_m     = w_alu_out;
    assign write_m   = rst_n && instr_valid && w_dec.is_c && w_dec.dst[0];
    assign address_m = r_a[AWIDTH-1:0];

endmodule

// File: tb/tb_my_cpu.sv
// Directed table-driven bench for my_cpu; A and D are observed through out_m with stalled probe instructions.
module tb_my_cpu;

    logic        clk;
    logic        rst_n;
    logic [15:0] instruction;
    logic        instr_valid;
    logic [15:0] in_m;
    logic [15:0] out_m;
    logic        write_m;
    logic [14:0] address_m;
    logic [14:0] pc;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] in_m;
        logic        chk_out;
        logic [15:0] exp_out;
        logic        exp_wm;
        logic [14:0] exp_addr;
        logic [14:0] exp_pc;
        logic [15:0] exp_a;
        logic [15:0] exp_d;
    } vec_t;

    vec_t vecs[18];

    my_cpu #(.WIDTH(16), .AWIDTH(15), .RESET_PC(15'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .in_m        (in_m),
        .out_m       (out_m),
        .write_m     (write_m),
        .address_m   (address_m),
        .pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    // Probe instructions run with instr_valid=0 so they never change state.
    task automatic probe_state(input string tag, input logic [14:0] e_pc,
                               input logic [15:0] e_a, input logic [15:0] e_d);
        instr_valid = 1'b0;
        check({tag, ":pc"}, 16'(pc), 16'(e_pc));
        instruction = 16'hEC00;
        #1 check({tag, ":A"}, out_m, e_a);
        instruction = 16'hE300;
        #1 check({tag, ":D"}, out_m, e_d);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        instruction = v.instr;
        in_m        = v.in_m;
        instr_valid = 1'b1;
        #1;
        check({tag, ":write_m"}, 16'(write_m), 16'(v.exp_wm));
        check({tag, ":address_m"}, 16'(address_m), 16'(v.exp_addr));
        if (v.chk_out)
            check({tag, ":out_m"}, out_m, v.exp_out);
        @(posedge clk);
        #1 probe_state(tag, v.exp_pc, v.exp_a, v.exp_d);
    endtask

    function automatic vec_t mk(input logic [15:0] ins, input logic [15:0] im, input logic co,
                                input logic [15:0] eo, input logic wm, input logic [14:0] ea,
                                input logic [14:0] ep, input logic [15:0] a, input logic [15:0] d);
        vec_t v;
        v.instr = ins; v.in_m = im; v.chk_out = co; v.exp_out = eo; v.exp_wm = wm;
        v.exp_addr = ea; v.exp_pc = ep; v.exp_a = a; v.exp_d = d;
        return v;
    endfunction

    initial begin
        //            instr     in_m      chk  out_m     wm    addr      pc        A         D
        vecs[0]  = mk(16'h0005, 16'h0000, 0, 16'h0000, 0, 15'h0000, 15'h0001, 16'h0005, 16'h0000);
        vecs[1]  = mk(16'hEC10, 16'h0000, 1, 16'h0005, 0, 15'h0005, 15'h0002, 16'h0005, 16'h0005);
        vecs[2]  = mk(16'hE090, 16'h0000, 1, 16'h000A, 0, 15'h0005, 15'h0003, 16'h0005, 16'h000A);
        vecs[3]  = mk(16'hE308, 16'h0000, 1, 16'h000A, 1, 15'h0005, 15'h0004, 16'h0005, 16'h000A);
        vecs[4]  = mk(16'h0010, 16'h0000, 0, 16'h0000, 0, 15'h0005, 15'h0005, 16'h0010, 16'h000A);
        vecs[5]  = mk(16'hEA87, 16'h0000, 1, 16'h0000, 0, 15'h0010, 15'h0010, 16'h0010, 16'h000A);
        vecs[6]  = mk(16'h0020, 16'h0000, 0, 16'h0000, 0, 15'h0010, 15'h0011, 16'h0020, 16'h000A);
        vecs[7]  = mk(16'hE302, 16'h0000, 0, 16'h0000, 0, 15'h0020, 15'h0012, 16'h0020, 16'h000A);
        vecs[8]  = mk(16'hEA90, 16'h0000, 0, 16'h0000, 0, 15'h0020, 15'h0013, 16'h0020, 16'h0000);
        vecs[9]  = mk(16'hE302, 16'h0000, 0, 16'h0000, 0, 15'h0020, 15'h0020, 16'h0020, 16'h0000);
        vecs[10] = mk(16'h0003, 16'h8000, 0, 16'h0000, 0, 15'h0020, 15'h0021, 16'h0003, 16'h0000);
        vecs[11] = mk(16'hFC20, 16'h8000, 1, 16'h8000, 0, 15'h0003, 15'h0022, 16'h8000, 16'h0000);
        vecs[12] = mk(16'hEC10, 16'h0000, 1, 16'h8000, 0, 15'h0000, 15'h0023, 16'h8000, 16'h8000);
        vecs[13] = mk(16'hE304, 16'h0000, 0, 16'h0000, 0, 15'h0000, 15'h0000, 16'h8000, 16'h8000);
        vecs[14] = mk(16'h0040, 16'h0000, 0, 16'h0000, 0, 15'h0000, 15'h0001, 16'h0040, 16'h8000);
        vecs[15] = mk(16'hEAA7, 16'h0000, 0, 16'h0000, 0, 15'h0040, 15'h0040, 16'h0000, 16'h8000);
        vecs[16] = mk(16'hE390, 16'h0000, 1, 16'h7FFF, 0, 15'h0000, 15'h0041, 16'h0000, 16'h7FFF);
        vecs[17] = mk(16'hE301, 16'h0000, 0, 16'h0000, 0, 15'h0000, 15'h0000, 16'h0000, 16'h7FFF);

        rst_n       = 1'b0;
        instruction = 16'hE308;
        instr_valid = 1'b1;
        in_m        = 16'h0000;
        #3 check("reset:write_m", 16'(write_m), 16'h0000);
        probe_state("reset", 15'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Stall: a dM instruction held with instr_valid=0 must neither write nor advance.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            instruction = 16'hE308;
            instr_valid = 1'b0;
            #1 check($sformatf("stall%0d:write_m", c), 16'(write_m), 16'h0000);
            @(posedge clk);
            #1 probe_state($sformatf("stall%0d", c), 15'h0000, 16'h0000, 16'h7FFF);
        end

        run_vec(mk(16'h1234, 16'h0000, 0, 16'h0000, 0, 15'h0000, 15'h0001, 16'h1234, 16'h7FFF), "pre_rst");

        // Asynchronous reset in the middle of a valid dM instruction.
        @(negedge clk);
        instruction = 16'hE308;
        instr_valid = 1'b1;
        #1 rst_n = 1'b0;
        #1 check("async_rst:write_m", 16'(write_m), 16'h0000);
        probe_state("async_rst", 15'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        run_vec(mk(16'h0005, 16'h0000, 0, 16'h0000, 0, 15'h0000, 15'h0001, 16'h0005, 16'h0000), "post_rst");
        run_vec(mk(16'h7FFF, 16'h0000, 0, 16'h0000, 0, 15'h0005, 15'h0002, 16'h7FFF, 16'h0000), "wrap_a");
        run_vec(mk(16'hEA87, 16'h0000, 0, 16'h0000, 0, 15'h7FFF, 15'h7FFF, 16'h7FFF, 16'h0000), "wrap_jmp");
        run_vec(mk(16'hE300, 16'h0000, 1, 16'h0000, 0, 15'h7FFF, 15'h0000, 16'h7FFF, 16'h0000), "wrap_inc");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/my_cpu.md
Name: my_cpu

Overview:
- Hack-style 16-bit CPU core that decodes instructions and drives the 16-bit ALU; the ALU is its execute stage.
- Holds the A, D and PC registers.
- Feeds ALU x/y plus the six control bits, consumes the ALU result and zero flag, and resolves jumps.
- Sits between instruction ROM and data RAM in the top-level computer.

Parameters:
- WIDTH, 16, data/register width; fixed at 16 to match the ALU.
- AWIDTH, 15, address and PC width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  clock; all registers update on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instruction  input  16  instruction word at address pc.
- instr_valid  input  1  instruction is present; when low the core stalls.
- in_m  input  16  data RAM read value at address_m (M).
- out_m  output  16  ALU result to be written to RAM.
- write_m  output  1  RAM write strobe for the current cycle.
- address_m  output  15  current A[14:0].
- pc  output  15  instruction fetch address.

Behaviour:
- Reset is asynchronous and active-low: rst_n=0 immediately forces A=0, D=0, pc=RESET_PC. write_m is forced to 0 combinationally while rst_n=0. out_m follows the ALU and is don't-care during reset.
- Instruction decode:
  - instruction[15]=0 is an A-instruction: A <= instruction.
  - instruction[15]=1 is a C-instruction. Bits [14:13] are ignored. Bit 12 = a. Bits [11:6] = zx nx zy ny f no. Bits [5:3] = dA dD dM. Bits [2:0] = jlt jeq jgt.
- ALU inputs: x = D; y = a ? in_m : A. The control bits connect directly.
- Flags: zero = ALU zr; negative = ALU out[15] (sign bit, taken from the result bus); positive = !zero & !negative.
- jump = C & ((jlt & negative) | (jeq & zero) | (jgt & positive)).
- Writeback on a rising edge with instr_valid=1:
  - A <= ALU out if C & dA; A <= instruction if A-instruction.
  - D <= ALU out if C & dD.
  - pc <= jump ? A[14:0] (pre-update value) : pc+1.
- With instr_valid=0, A, D and pc all hold.
- write_m = rst_n & instr_valid & C & dM (combinational, same cycle). out_m = ALU out. address_m = pre-update A[14:0].
- Single-cycle latency: register effects are visible the cycle after the valid edge.
- PC arithmetic is mod 2^15: 0x7FFF+1 wraps to 0x0000.
- An instruction with both dA and a jump uses the old A as the jump target and loads the new A.
- Reset deassertion: the first valid instruction executes from RESET_PC. Reset asserted mid-stall or mid-instruction discards that instruction with no write.

Decomposition:
- Shared package (cpu_pkg): instruction bit-position constants (BIT_CI, BIT_A, slices for the ALU control, dest and jump fields), WIDTH/AWIDTH, and a typedef for the decoded C-instruction struct.
- Sub-module: my_pc, a 15-bit register with async active-low reset, load, inc and hold (priority load > inc > hold). The core also instantiates the existing my_alu.

Test Plan:
1. Reset, then instruction 0x0005 valid -> next cycle A=5, address_m=5, pc=1, write_m=0.
2. After step 1: 0xEC10 (D=A), then 0xE090 (D=D+A) -> D=5, then D=10; pc=3.
3. Then 0xE308 (M=D) -> write_m=1 and out_m=0x000A in the same cycle; address_m=5; D and A unchanged.
4. A=0x0010, then 0xEA87 (0;JMP) -> pc=0x0010. With D=0, 0xE302 (D;JEQ) after A=0x20 -> pc=0x20. With D=10 the same instruction -> pc+1.
5. in_m=0x8000, A=3, then 0xFC20 (A=M) -> address_m=3 during the instruction, A=0x8000 after. Following 0xEC10-style D=A sets D=0x8000, and D;JLT jumps.
6. Hold instr_valid=0 for 3 cycles -> pc, A and D frozen, write_m=0. Pulse rst_n low asynchronously mid-cycle -> immediate pc=0, A=0, D=0. pc=0x7FFF with a non-jump instruction -> pc=0x0000.
